// File: rtl/femto_localbus_bridge_pkg.sv
// rtl/femto_localbus_bridge_pkg.sv - shared types and helpers for the FemtoRV32 local-bus bridge
// Purpose: bridge state encoding, default abort read value, local-bus address
// width and the zero-extension rule applied to forwarded CPU addresses.
// Ports: none (package).
package femto_localbus_bridge_pkg;

  localparam int          LB_ADDR_W    = 32;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } bridge_state_t;

  // Keep the low 'bits' address bits, zero the rest. For bits >= 32 the
  // shift yields 0 and the subtraction wraps to all ones (full pass-through).
  function automatic logic [LB_ADDR_W-1:0] lb_zext(input logic [LB_ADDR_W-1:0] addr,
                                                   input int unsigned bits);
    logic [LB_ADDR_W-1:0] mask;
    mask = (LB_ADDR_W'(1) << bits) - LB_ADDR_W'(1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// rtl/bridge_timeout_cnt.sv - saturating wait-cycle counter for the local-bus bridge
// Purpose: counts wait cycles of an outstanding local-bus access and flags
// when the count has reached TIMEOUT.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - start a new access: count becomes 1
//   inc       - one more wait cycle; holds at 255 instead of wrapping
//   expired   - count has reached TIMEOUT
module bridge_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (load) begin
      cnt_q <= 8'd1;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired = (cnt_q >= TMO);

endmodule

// File: rtl/femto_localbus_bridge.sv
// rtl/femto_localbus_bridge.sv - FemtoRV32 memory-port responder re-issuing accesses on the local bus
// Purpose: captures selected CPU reads/writes, issues them as single-cycle
// ren/wen requests, stalls the CPU via mem_rbusy/mem_wbusy until rvalid/wready,
// and aborts with ERR_DATA and a sticky bus_err if the slave stays silent.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   sel, mem_addr, mem_wdata,
//   mem_wmask, mem_rstrb              - CPU request side
//   mem_rdata, mem_rbusy, mem_wbusy   - CPU response side
//   waddr, wdata, wen, wstrb, wready  - local-bus write channel
//   raddr, ren, rdata, rvalid         - local-bus read channel
//   bus_err, err_clr                  - sticky timeout flag and its clear
module femto_localbus_bridge
  import femto_localbus_bridge_pkg::*;
#(
  parameter int          ADDR_BITS = 28,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        wen,
  output logic [3:0]  wstrb,
  input  logic        wready,
  output logic [31:0] raddr,
  output logic        ren,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        bus_err,
  input  logic        err_clr
);

  bridge_state_t state_q, state_d;

  logic cap_rd, cap_wr;
  logic rd_done, rd_abort, wr_abort;
  logic cnt_load, cnt_inc, expired;

  bridge_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_rd   = 1'b0;
    cap_wr   = 1'b0;
    rd_done  = 1'b0;
    rd_abort = 1'b0;
    wr_abort = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A write strobe in the same cycle as a read strobe wins; the read is dropped.
        if (sel && (|mem_wmask)) begin
          cap_wr  = 1'b1;
          state_d = ST_WR_REQ;
        end else if (sel && mem_rstrb) begin
          cap_rd  = 1'b1;
          state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        cnt_load = 1'b1;
        if (rvalid) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rvalid) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end else if (expired) begin
          rd_abort = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_WR_REQ: begin
        cnt_load = 1'b1;
        state_d  = wready ? ST_IDLE : ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (wready) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          wr_abort = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rdata <= 32'd0;
      bus_err   <= 1'b0;
      raddr     <= 32'd0;
      waddr     <= 32'd0;
      wdata     <= 32'd0;
      wstrb     <= 4'd0;
    end else begin
      if (cap_rd) begin
        raddr <= lb_zext(mem_addr, ADDR_BITS);
      end
      if (cap_wr) begin
        waddr <= lb_zext(mem_addr, ADDR_BITS);
        wdata <= mem_wdata;
        wstrb <= mem_wmask;
      end
      if (rd_done) begin
        mem_rdata <= rdata;
      end else if (rd_abort) begin
        mem_rdata <= ERR_DATA;
      end
      // A timeout in the same cycle as err_clr keeps the flag set.
      if (rd_abort || wr_abort) begin
        bus_err <= 1'b1;
      end else if (err_clr) begin
        bus_err <= 1'b0;
      end
    end
  end

  assign ren       = (state_q == ST_RD_REQ);
  assign wen       = (state_q == ST_WR_REQ);
  assign mem_rbusy = (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
  assign mem_wbusy = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);

endmodule

// File: tb/tb_femto_localbus_bridge.sv
// tb/tb_femto_localbus_bridge.sv - self-checking bench for femto_localbus_bridge
module tb_femto_localbus_bridge;

  localparam int          TMO  = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, ren, wready, rvalid;
  logic [3:0]  wstrb;
  logic        bus_err, err_clr;

  femto_localbus_bridge dut (
    .clk(clk), .rst(rst), .sel(sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .waddr(waddr), .wdata(wdata),
    .wen(wen), .wstrb(wstrb), .wready(wready), .raddr(raddr), .ren(ren),
    .rdata(rdata), .rvalid(rvalid), .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: last value the CPU should see and the sticky error flag.
  logic [31:0] exp_rdata;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU access. d = cycles after the ren/wen cycle at which the slave acks
  // (0 = same cycle). The expected outcome follows from the protocol rules:
  // ack within TMO wait cycles succeeds with d+1 busy cycles, otherwise the
  // access aborts after TMO+1 busy cycles.
  task automatic access(input logic s, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] wm,
                        input int d, input logic [31:0] rd_val);
    logic        is_w, is_r, ok, done;
    int          exp_busy, rb, wb, rp, wp;
    logic [31:0] la, prev;
    is_w = s && (wm != 4'd0);
    is_r = s && rd && !is_w;
    ok   = (d <= TMO);
    exp_busy = (is_w || is_r) ? (ok ? d + 1 : TMO + 1) : 0;
    la   = a & 32'h0FFF_FFFF;
    prev = exp_rdata;
    rb = 0; wb = 0; rp = 0; wp = 0; done = 1'b0;
    sel = s; mem_addr = a; mem_wdata = wd; mem_wmask = wm; mem_rstrb = rd;
    @(negedge clk);
    sel = 1'b0; mem_wmask = 4'd0; mem_rstrb = 1'b0;
    mem_addr = $urandom; mem_wdata = $urandom;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (!mem_rbusy && !mem_wbusy) begin
        done = 1'b1;
      end else begin
        rb += int'(mem_rbusy); wb += int'(mem_wbusy);
        rp += int'(ren);       wp += int'(wen);
        if (mem_rbusy) begin
          check("raddr", raddr, la);
          check("rdata_hold", mem_rdata, prev);
        end
        if (mem_wbusy) begin
          check("waddr", waddr, la);
          check("wdata", wdata, wd);
          check("wstrb", {28'd0, wstrb}, {28'd0, wm});
        end
        rvalid = is_r && (c == d + 1);
        wready = is_w && (c == d + 1);
        rdata  = rvalid ? rd_val : $urandom;
        @(negedge clk);
        rvalid = 1'b0; wready = 1'b0;
      end
    end
    if (is_r) exp_rdata = ok ? rd_val : ERRD;
    if ((is_r || is_w) && !ok) exp_err = 1'b1;
    check("rbusy_cycles", rb, is_r ? exp_busy : 0);
    check("wbusy_cycles", wb, is_w ? exp_busy : 0);
    check("ren_pulses", rp, is_r ? 1 : 0);
    check("wen_pulses", wp, is_w ? 1 : 0);
    check("ren_idle", {31'd0, ren}, 32'd0);
    check("wen_idle", {31'd0, wen}, 32'd0);
    check("mem_rdata", mem_rdata, exp_rdata);
    check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("bus_err_clr", {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    mem_rstrb = 1'b0; wready = 1'b0; rvalid = 1'b0; rdata = '0; err_clr = 1'b0;
    exp_rdata = '0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_busy", {30'd0, mem_rbusy, mem_wbusy}, 32'd0);
    check("rst_strobes", {30'd0, ren, wen}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_raddr", raddr, 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", {28'd0, wstrb}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    access(1'b1, 1'b1, 32'h4000_0008, 32'd0, 4'd0, 1, 32'h0000_A5A5);
    access(1'b1, 1'b0, 32'h4000_0004, 32'h0000_00FF, 4'b0011, 3, 32'd0);
    access(1'b1, 1'b1, 32'h4000_0010, 32'd0, 4'd0, 40, 32'h1234_5678);
    rvalid = 1'b1; rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rvalid = 1'b0;
    check("late_rvalid", mem_rdata, ERRD);
    check("late_rbusy", {31'd0, mem_rbusy}, 32'd0);
    pulse_clr();
    access(1'b1, 1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'hF, 2, 32'd0);
    access(1'b0, 1'b1, 32'h4000_0030, 32'h1111_2222, 4'hF, 0, 32'd0);
    access(1'b0, 1'b1, 32'h4000_0034, 32'd0, 4'd0, 0, 32'h3333_4444);
    access(1'b1, 1'b1, 32'h4000_0040, 32'd0, 4'd0, 0, 32'h5555_6666);
    access(1'b1, 1'b1, 32'h4000_0044, 32'd0, 4'd0, TMO, 32'h7777_8888);
    // Timeout coinciding with err_clr: flag must stay set.
    err_clr = 1'b1;
    access(1'b1, 1'b0, 32'hF000_0050, 32'hABCD_0123, 4'b1000, TMO + 1, 32'd0);
    err_clr = 1'b0;
    pulse_clr();

    // Reset in the middle of a read.
    sel = 1'b1; mem_addr = 32'h4000_0060; mem_rstrb = 1'b1;
    @(negedge clk);
    sel = 1'b0; mem_rstrb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_rdata = '0; exp_err = 1'b0;
    check("mid_rst_rbusy", {31'd0, mem_rbusy}, 32'd0);
    check("mid_rst_rdata", mem_rdata, 32'd0);
    check("mid_rst_ren", {31'd0, ren}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ren", {30'd0, ren, mem_rbusy}, 32'd0);
    access(1'b1, 1'b1, 32'h4000_0064, 32'd0, 4'd0, 2, 32'h9999_AAAA);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic        s, rd;
      logic [3:0]  wm;
      int          kind;
      s    = ($urandom_range(0, 7) != 0);
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wm   = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      access(s, rd, $urandom, $urandom, wm, $urandom_range(0, 20), $urandom);
      if ($urandom_range(0, 5) == 0) pulse_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
